// File: rtl/johnson_step_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_step_ctrl
//   Command-driven sequencer for an N-bit Johnson (twisted-ring) counter.
//   A host hands over one command (direction, step count, step period) on a
//   valid/ready handshake.  The block then advances the phase register one
//   position per period, forward or reverse, until the count runs out or the
//   host aborts.  A one-cycle done pulse marks the end of every command.
//
//   Optional build macro: JOHNSON_STEP_ILLEGAL_DET_EN
//     defined   - phase register is checked every cycle; an illegal code is
//                 reloaded to the reset phase and o_err latches high.
//     undefined - no checker, o_err tied low.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset_n      synchronous active-low reset
//   i_cmd_valid    command offered
//   o_cmd_ready    command can be accepted (IDLE only)
//   i_cmd_dir      1 = forward, 0 = reverse
//   i_cmd_steps    number of steps to perform
//   i_cmd_div      step period minus one, in clocks
//   i_abort        terminate running command
//   o_q            Johnson phase state
//   o_busy         command running
//   o_done         one-cycle completion/abort pulse
//   o_steps_left   remaining steps of the current command
//   o_err          sticky illegal-phase flag
//
// State | meaning
//   IDLE | waiting for a command, o_cmd_ready high
//   RUN  | prescaler counting down, stepping q at terminal count
//   DONE | single cycle, o_done high, then back to IDLE
// ---------------------------------------------------------------------------
module johnson_step_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_dir,
    input  logic [CNT_W-1:0] i_cmd_steps,
    input  logic [DIV_W-1:0] i_cmd_div,
    input  logic             i_abort,
    output logic [N-1:0]     o_q,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_steps_left,
    output logic             o_err
);

    localparam logic [N-1:0] Q_INIT = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_q;
    logic             r_dir;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_presc;
    logic [CNT_W-1:0] r_steps_left;

    state_t           w_state_nxt;
    logic [N-1:0]     w_q_nxt;
    logic             w_dir_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_presc_nxt;
    logic [CNT_W-1:0] w_steps_nxt;
    logic [N-1:0]     w_q_fwd;
    logic [N-1:0]     w_q_rev;

    assign w_q_fwd = {~r_q[0], r_q[N-1:1]};
    assign w_q_rev = {r_q[N-2:0], ~r_q[N-1]};

`ifdef JOHNSON_STEP_ILLEGAL_DET_EN
    logic         r_err;
    logic         w_err_nxt;
    logic [N-2:0] w_trans;
    logic         w_legal;

    // A legal Johnson code is a single run of ones and a single run of zeros,
    // i.e. at most one bit boundary where neighbouring bits differ.
    assign w_trans = r_q[N-1:1] ^ r_q[N-2:0];
    assign w_legal = $onehot0(w_trans);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_dir_nxt   = r_dir;
        w_div_nxt   = r_div;
        w_presc_nxt = r_presc;
        w_steps_nxt = r_steps_left;

        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_dir_nxt   = i_cmd_dir;
                    w_div_nxt   = i_cmd_div;
                    w_presc_nxt = i_cmd_div;
                    w_steps_nxt = i_cmd_steps;
                    w_state_nxt = (i_cmd_steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over a step that falls due this cycle.
                if (i_abort) begin
                    w_state_nxt = S_DONE;
                end else if (r_presc != '0) begin
                    w_presc_nxt = r_presc - DIV_W'(1);
                end else begin
                    w_q_nxt     = r_dir ? w_q_fwd : w_q_rev;
                    w_steps_nxt = r_steps_left - CNT_W'(1);
                    w_presc_nxt = r_div;
                    if (r_steps_left == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef JOHNSON_STEP_ILLEGAL_DET_EN
        w_err_nxt = r_err;
        // Recovery overrides any step computed above; FSM keeps going.
        if (!w_legal) begin
            w_q_nxt   = Q_INIT;
            w_err_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_q          <= Q_INIT;
            r_dir        <= 1'b0;
            r_div        <= '0;
            r_presc      <= '0;
            r_steps_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_q          <= w_q_nxt;
            r_dir        <= w_dir_nxt;
            r_div        <= w_div_nxt;
            r_presc      <= w_presc_nxt;
            r_steps_left <= w_steps_nxt;
        end
    end

`ifdef JOHNSON_STEP_ILLEGAL_DET_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state == S_RUN);
    assign o_done       = (r_state == S_DONE);
    assign o_q          = r_q;
    assign o_steps_left = r_steps_left;

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_johnson_step_ctrl
//   Directed bench for johnson_step_ctrl (N=4, CNT_W=16, DIV_W=16).
//   Each command pushes the expected (cycle, phase) of every step into a
//   scoreboard queue; entries are popped as the phase output changes.
// ---------------------------------------------------------------------------
module tb_johnson_step_ctrl;

    logic        i_clock;
    logic        i_reset_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_dir;
    logic [15:0] i_cmd_steps;
    logic [15:0] i_cmd_div;
    logic        i_abort;
    logic [3:0]  o_q;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_steps_left;
    logic        o_err;

    johnson_step_ctrl #(.N(4), .CNT_W(16), .DIV_W(16)) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_dir    (i_cmd_dir),
        .i_cmd_steps  (i_cmd_steps),
        .i_cmd_div    (i_cmd_div),
        .i_abort      (i_abort),
        .o_q          (o_q),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_steps_left (o_steps_left),
        .o_err        (o_err)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        int         cyc;
        logic [3:0] q;
    } sb_t;

    sb_t        sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] q_model;
    logic [3:0] seq [8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};

    task automatic tick();
        @(posedge i_clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next phase from the forward sequence table, independent of the shift rule.
    function automatic logic [3:0] jstep(input logic [3:0] v, input logic dir);
        int idx = 0;
        for (int i = 0; i < 8; i++) if (seq[i] == v) idx = i;
        return dir ? seq[(idx + 1) % 8] : seq[(idx + 7) % 8];
    endfunction

    task automatic do_reset();
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        q_model   = 4'h8;
    endtask

    // abort_at < 0: no abort; otherwise abort is held during the RUN cycle
    // following edge accept+abort_at.
    task automatic send_cmd(input logic dir, input int steps, input int div, input int abort_at);
        int   k, e_rel, n_exp, n_busy, n_done, done_cyc;
        logic finished;
        logic [3:0] prev;
        sb_t  ent;

        e_rel = (div + 1) * steps;
        n_exp = steps;
        if (steps > 0 && abort_at >= 0 && abort_at + 1 <= e_rel) begin
            e_rel = abort_at + 1;
            n_exp = abort_at / (div + 1);
        end

        chk("ready_before_accept", {31'd0, o_cmd_ready}, 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_dir   = dir;
        i_cmd_steps = 16'(steps);
        i_cmd_div   = 16'(div);
        tick();
        k = cyc;
        for (int i = 1; i <= n_exp; i++) begin
            q_model = jstep(q_model, dir);
            ent.cyc = k + (div + 1) * i;
            ent.q   = q_model;
            sb.push_back(ent);
        end
        // Later changes to the command fields must not matter.
        i_cmd_valid = 1'b0;
        i_cmd_dir   = ~dir;
        i_cmd_steps = 16'h0007;
        i_cmd_div   = 16'hFFFF;

        prev     = o_q;
        n_busy   = 0;
        n_done   = 0;
        done_cyc = -1;
        finished = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (n_done > 0 && !o_done) begin
                i_cmd_valid = 1'b0;
                finished    = 1'b1;
                break;
            end
            if (o_q !== prev) begin
                if (sb.size() == 0) begin
                    chk("extra_step_q", {28'd0, o_q}, {28'd0, prev});
                end else begin
                    ent = sb.pop_front();
                    chk("step_q", {28'd0, o_q}, {28'd0, ent.q});
                    chk("step_cyc", cyc, ent.cyc);
                end
                prev = o_q;
            end
            if (o_busy) n_busy++;
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
                // Offer a command during DONE; it must be ignored.
                i_cmd_valid = 1'b1;
            end
            i_abort = (abort_at >= 0 && (cyc - k) == abort_at);
            tick();
        end
        i_abort     = 1'b0;
        i_cmd_valid = 1'b0;

        chk("cmd_finished", {31'd0, finished}, 32'd1);
        chk("pending_steps", sb.size(), 0);
        sb.delete();
        chk("done_pulses", n_done, 1);
        chk("done_cyc", done_cyc, k + e_rel);
        chk("busy_cycles", n_busy, (steps == 0) ? 0 : e_rel);
        chk("steps_left", {16'd0, o_steps_left}, 32'(16'(steps - n_exp)));
        chk("ready_after", {31'd0, o_cmd_ready}, 32'd1);
        chk("q_after", {28'd0, o_q}, {28'd0, q_model});
        chk("err_after", {31'd0, o_err}, 32'd0);
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_dir   = 1'b0;
        i_cmd_steps = '0;
        i_cmd_div   = '0;
        i_abort     = 1'b0;
        q_model     = 4'h8;

        // Reset state, with other inputs active to show reset dominates.
        i_cmd_valid = 1'b1;
        i_abort     = 1'b1;
        tick();
        tick();
        chk("rst_q", {28'd0, o_q}, 32'h8);
        chk("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_steps_left", {16'd0, o_steps_left}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        i_cmd_valid = 1'b0;
        i_abort     = 1'b0;
        i_reset_n   = 1'b1;
        tick();
        q_model = 4'h8;

        // Forward 3 steps, back-to-back.
        send_cmd(1'b1, 3, 0, -1);
        chk("t1_q", {28'd0, o_q}, 32'hF);

        // Reverse 2 from the reset phase.
        do_reset();
        send_cmd(1'b0, 2, 0, -1);
        chk("t2_q", {28'd0, o_q}, 32'h1);

        // Full forward ring with a 3-clock period returns to the start.
        do_reset();
        send_cmd(1'b1, 8, 2, -1);
        chk("t3_q", {28'd0, o_q}, 32'h8);

        // Abort during the third RUN cycle.
        do_reset();
        send_cmd(1'b1, 5, 0, 2);
        chk("t4_q", {28'd0, o_q}, 32'hE);
        chk("t4_steps_left", {16'd0, o_steps_left}, 32'd3);

        // Zero-step command: no movement, immediate done.
        send_cmd(1'b1, 0, 7, -1);
        chk("t5_q", {28'd0, o_q}, 32'hE);

        // Abort on the same cycle a step falls due: the step is dropped.
        send_cmd(1'b0, 4, 1, 3);
        chk("abort_due_q", {28'd0, o_q}, 32'hC);
        chk("abort_due_left", {16'd0, o_steps_left}, 32'd3);

        // Reverse wrap past the ring length.
        send_cmd(1'b0, 10, 0, -1);

        // Reset in the middle of RUN.
        chk("mid_ready", {31'd0, o_cmd_ready}, 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_dir   = 1'b1;
        i_cmd_steps = 16'd5;
        i_cmd_div   = 16'd3;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy_before", {31'd0, o_busy}, 32'd1);
        i_reset_n   = 1'b0;
        i_cmd_valid = 1'b1;
        i_abort     = 1'b1;
        tick();
        chk("mid_rst_q", {28'd0, o_q}, 32'h8);
        chk("mid_rst_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        chk("mid_rst_left", {16'd0, o_steps_left}, 32'd0);
        i_reset_n   = 1'b1;
        i_cmd_valid = 1'b0;
        i_abort     = 1'b0;
        q_model     = 4'h8;
        tick();
        chk("mid_idle_hold", {31'd0, o_cmd_ready}, 32'd1);
        send_cmd(1'b1, 2, 1, -1);

`ifdef JOHNSON_STEP_ILLEGAL_DET_EN
        force dut.r_q = 4'b1010;
        #2;
        release dut.r_q;
        tick();
        chk("ill_q", {28'd0, o_q}, 32'h8);
        chk("ill_err", {31'd0, o_err}, 32'd1);
        tick();
        tick();
        chk("ill_err_sticky", {31'd0, o_err}, 32'd1);
        do_reset();
        chk("ill_err_cleared", {31'd0, o_err}, 32'd0);
`else
        tick();
        chk("err_off", {31'd0, o_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
